seq_pattern_tx: RTL
===================

// Module: seq_pattern_tx
// PURPOSE
//   Serial frame generator, the transmit end of the 1101 sequence-detector link.
//   Each frame is a PAT_W-bit sync pattern (default 1101), MSB first, then a DATA_W-bit payload, MSB first.
//   Frame starts use a valid/ready handshake; GAP_CYC idle cycles follow each frame.
//   Drives the serial input of the downstream Mealy 1101 detector.
// PARAMETERS
//   PAT_W    4        sync pattern width, >=1
//   PATTERN  4'b1101  sync pattern, sent bit PAT_W-1 first
//   DATA_W   8        payload width, >=1
//   GAP_CYC  2        idle cycles after each frame, >=0
// PORTS
//   clk          in   1       rising-edge clock
//   rst_n        in   1       asynchronous active-low reset
//   start_valid  in   1       frame request
//   start_ready  out  1       high only in IDLE; accept = start_valid & start_ready at clk edge
//   data_in      in   DATA_W  payload, sampled only on the accept edge
//   bit_out      out  1       serial bit (registered)
//   bit_valid    out  1       high while a pattern or payload bit is on bit_out
//   sync_done    out  1       1-cycle pulse while the last pattern bit is driven
//   frame_done   out  1       1-cycle pulse while the last payload bit is driven
//   busy         out  1       ~start_ready
//   st           out  2       state code, for debug only
// BEHAVIOUR
//   States (st): IDLE=00, SYNC=01, DATA=10, GAP=11.
//     Single counter cnt, width $clog2(max(PAT_W,DATA_W,GAP_CYC)+1).
//   Reset (rst_n=0, takes effect immediately, no clock needed):
//     State -> IDLE, cnt=0, shift register=0.
//     bit_out=0, bit_valid=0, sync_done=0, frame_done=0, busy=0, start_ready=1.
//   IDLE: start_ready=1.
//     On accept: latch data_in into shift register, go to SYNC, cnt=0.
//     On the same edge, drive bit_out=PATTERN[PAT_W-1] and bit_valid=1.
//   SYNC: one bit per cycle, PATTERN[PAT_W-1-cnt].
//     sync_done=1 in the cycle PATTERN[0] is driven.
//     After PAT_W bits, go to DATA.
//   DATA: shift out MSB first, one bit per cycle.
//     frame_done=1 in the cycle payload bit 0 is driven.
//     After DATA_W bits: go to GAP if GAP_CYC>0, else to IDLE.
//   GAP: bit_out=0, bit_valid=0 for GAP_CYC cycles, then go to IDLE.
//   Latency, accept at edge k, defaults:
//     bits valid in cycles k+1..k+12, gap cycles k+13..k+14.
//     start_ready=1 from cycle k+15. Frame period = 1+PAT_W+DATA_W+GAP_CYC cycles.
//   GAP_CYC=0: the cycle after frame_done is IDLE with bit_out=0, bit_valid=0.
//     So frames are always separated by at least 1 idle cycle.
//   bit_valid=0 implies bit_out=0. sync_done and frame_done are never high outside bit_valid.
//   start_valid while busy: ignored, nothing is queued.
//     A request still high when start_ready rises is accepted on that edge.
//   Changes to data_in after the accept edge do not affect the frame in flight.
//   Reset mid-frame: the frame is abandoned. No partial sync_done or frame_done follows release.
//   The payload is not escaped. Payloads containing the pattern, or forming it together with
//     the pattern tail, are allowed; the receiver handles framing.
// TESTING
//   T1 data_in=8'hA5, one accept:
//      bit_out = 1,1,0,1,1,0,1,0,0,1,0,1 with bit_valid=1.
//      sync_done in bit 4, frame_done in bit 12, then 2 cycles bit_valid=0, then start_ready=1.
//   T2 start_valid held high, data 8'h3C then 8'hC3:
//      accepts exactly 15 cycles apart; second stream = 1101 11000011.
//   T3 rst_n pulled low at bit 6 of a frame:
//      all outputs 0 and start_ready=1 within the reset cycle. New frame 8'h00 after release
//      streams cleanly.
//   T4 loopback into the 1101 detector, payload 8'h00, 3 frames:
//      detector q asserts exactly 3 times, each in the same cycle as sync_done.
//   T5 start_valid pulsed at cycles k+3 and k+10 during a frame:
//      no extra accept, the frame is unchanged.
//   T6 GAP_CYC=0, PAT_W=3, PATTERN=3'b101, DATA_W=4, back-to-back:
//      accepts 8 cycles apart, 7 valid bits per frame.

Source files
------------

// File: rtl/seq_pattern_tx_if.sv
// Bus bundle for the serial frame generator.
// The master side requests frames and observes the serial stream.
// The slave side is the generator itself.
interface seq_pattern_tx_if #(
    parameter int DATA_W = 8
) ();
    logic              start_valid;
    logic              start_ready;
    logic [DATA_W-1:0] data_in;
    logic              bit_out;
    logic              bit_valid;
    logic              sync_done;
    logic              frame_done;
    logic              busy;
    logic [1:0]        st;

    modport master (
        output start_valid, data_in,
        input  start_ready, bit_out, bit_valid, sync_done, frame_done, busy, st
    );

    modport slave (
        input  start_valid, data_in,
        output start_ready, bit_out, bit_valid, sync_done, frame_done, busy, st
    );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial frame generator: sends a sync pattern (MSB first), then a payload
// (MSB first), then a fixed number of idle gap cycles. Frames start on a
// valid/ready handshake that is only open while idle.
module seq_pattern_tx #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
    parameter int               DATA_W  = 8,
    parameter int               GAP_CYC = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    seq_pattern_tx_if.slave bus
);

    // One counter is shared by all phases, so it must cover the longest one.
    localparam int MAX_PD  = (PAT_W > DATA_W) ? PAT_W : DATA_W;
    localparam int MAX_ALL = (MAX_PD > GAP_CYC) ? MAX_PD : GAP_CYC;
    localparam int CW      = $clog2(MAX_ALL + 1);

    localparam logic [CW-1:0] PAT_LAST  = CW'(PAT_W - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SYNC = 2'b01,
        DATA = 2'b10,
        GAP  = 2'b11
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_inc;
    logic [DATA_W-1:0] data_sh;
    logic [PAT_W-1:0]  pat_sh;
    logic              accept;

    assign accept  = bus.start_valid && (state == IDLE);
    assign cnt_inc = cnt + CW'(1);

    // Handshake and status are pure decodes of the registered state.
    assign bus.start_ready = (state == IDLE);
    assign bus.busy        = (state != IDLE);
    assign bus.st          = state;

    // Frame sequencer: cnt holds the index of the bit currently on bit_out,
    // and every output is loaded one edge ahead of the cycle it describes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            data_sh        <= '0;
            pat_sh         <= '0;
            bus.bit_out    <= 1'b0;
            bus.bit_valid  <= 1'b0;
            bus.sync_done  <= 1'b0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.bit_out    <= 1'b0;
            bus.bit_valid  <= 1'b0;
            bus.sync_done  <= 1'b0;
            bus.frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state         <= SYNC;
                        cnt           <= '0;
                        data_sh       <= bus.data_in;
                        pat_sh        <= PATTERN << 1;
                        bus.bit_out   <= PATTERN[PAT_W-1];
                        bus.bit_valid <= 1'b1;
                        bus.sync_done <= (PAT_W == 1);
                    end
                end
                SYNC: begin
                    bus.bit_valid <= 1'b1;
                    if (cnt == PAT_LAST) begin
                        state          <= DATA;
                        cnt            <= '0;
                        bus.bit_out    <= data_sh[DATA_W-1];
                        data_sh        <= data_sh << 1;
                        bus.frame_done <= (DATA_W == 1);
                    end else begin
                        cnt           <= cnt_inc;
                        bus.bit_out   <= pat_sh[PAT_W-1];
                        pat_sh        <= pat_sh << 1;
                        bus.sync_done <= (cnt_inc == PAT_LAST);
                    end
                end
                DATA: begin
                    if (cnt == DATA_LAST) begin
                        cnt   <= '0;
                        state <= (GAP_CYC > 0) ? GAP : IDLE;
                    end else begin
                        cnt            <= cnt_inc;
                        bus.bit_valid  <= 1'b1;
                        bus.bit_out    <= data_sh[DATA_W-1];
                        data_sh        <= data_sh << 1;
                        bus.frame_done <= (cnt_inc == DATA_LAST);
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
